modular_subtractor: RTL and testbench

MODULAR_SUBTRACTOR -- requirements
Module: modular_subtractor

---
 rtl/mod_arith_pkg.sv | 9 +
 rtl/mod_sub_core.sv | 32 +++
 rtl/modular_subtractor.sv | 113 +++++++++++
 tb/tb_modular_subtractor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic blocks.
// Default operand width and the operand vector type.
package mod_arith_pkg;

  localparam int unsigned MOD_N_BITS = 7;

  typedef logic [MOD_N_BITS-1:0] operand_t;

endpackage

// File: rtl/mod_sub_core.sv
// Combinational core: raw difference, corrected difference,
// borrow and operand range flags for (A - B) mod (2^N - K).
module mod_sub_core
  import mod_arith_pkg::*;
#(
  parameter int unsigned N_BITS = MOD_N_BITS
) (
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic [N_BITS-1:0] k_i,
  output logic [N_BITS:0]   d0_o,
  output logic [N_BITS-1:0] d1_o,
  output logic              borrow_o,
  output logic              a_oor_o,
  output logic              b_oor_o
);

  logic [N_BITS:0] a_k;
  logic [N_BITS:0] b_k;

  assign d0_o     = {1'b0, a_i} - {1'b0, b_i};
  // Subtracting K mod 2^N is the same as adding M mod 2^N
  assign d1_o     = d0_o[N_BITS-1:0] - k_i;
  assign borrow_o = d0_o[N_BITS];

  // x >= M exactly when x + K reaches 2^N
  assign a_k      = {1'b0, a_i} + {1'b0, k_i};
  assign b_k      = {1'b0, b_i} + {1'b0, k_i};
  assign a_oor_o  = a_k[N_BITS];
  assign b_oor_o  = b_k[N_BITS];

endmodule

// File: rtl/modular_subtractor.sv
// Two-stage pipelined modular subtractor with valid/ready
// handshake on both sides; result is (A - B) mod (2^N - K).
module modular_subtractor
  import mod_arith_pkg::*;
#(
  parameter int unsigned N_BITS = MOD_N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] A_vector,
  input  logic [N_BITS-1:0] B_vector,
  input  logic [N_BITS-1:0] K_vector,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff_vector,
  output logic              wrap_out,
  output logic              range_err
);

  logic [N_BITS:0]   c_d0;
  logic [N_BITS-1:0] c_d1;
  logic              c_borrow;
  logic              c_a_oor;
  logic              c_b_oor;

  logic              v1_q, v1_d;
  logic [N_BITS:0]   d0_q, d0_d;
  logic [N_BITS-1:0] d1_q, d1_d;
  logic              err1_q, err1_d;

  logic              ov_q, ov_d;
  logic [N_BITS-1:0] diff_q, diff_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic              adv1;
  logic              adv2;

  mod_sub_core #(
    .N_BITS (N_BITS)
  ) u_core (
    .a_i      (A_vector),
    .b_i      (B_vector),
    .k_i      (K_vector),
    .d0_o     (c_d0),
    .d1_o     (c_d1),
    .borrow_o (c_borrow),
    .a_oor_o  (c_a_oor),
    .b_oor_o  (c_b_oor)
  );

  assign adv2     = !ov_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    v1_d   = v1_q;
    d0_d   = d0_q;
    d1_d   = d1_q;
    err1_d = err1_q;
    ov_d   = ov_q;
    diff_d = diff_q;
    wrap_d = wrap_q;
    err_d  = err_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        d0_d   = c_d0;
        d1_d   = c_d1;
        err1_d = c_a_oor || c_b_oor;
      end
    end
    // Data only moves with a valid token, so held outputs stay put
    if (adv2) begin
      ov_d = v1_q;
      if (v1_q) begin
        diff_d = d0_q[N_BITS] ? d1_q : d0_q[N_BITS-1:0];
        wrap_d = d0_q[N_BITS];
        err_d  = err1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      err1_q <= 1'b0;
      ov_q   <= 1'b0;
      diff_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      err1_q <= err1_d;
      ov_q   <= ov_d;
      diff_q <= diff_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out_valid   = ov_q;
  assign diff_vector = diff_q;
  assign wrap_out    = wrap_q;
  assign range_err   = err_q;

endmodule

// File: tb/tb_modular_subtractor.sv
// Directed bench for modular_subtractor with an in-order
// scoreboard of expected results (N=7, mostly K=20, M=108).
module tb_modular_subtractor;
  import mod_arith_pkg::*;

  typedef struct packed {
    logic [6:0] diff;
    logic       wrap;
    logic       err;
  } exp_t;

  logic     clk;
  logic     rst_n;
  logic     in_valid;
  logic     in_ready;
  operand_t A_vector;
  operand_t B_vector;
  operand_t K_vector;
  logic     out_valid;
  logic     out_ready;
  operand_t diff_vector;
  logic     wrap_out;
  logic     range_err;

  exp_t     sb[$];
  int       checks;
  int       passed;
  int       fails;
  int       delivered;
  logic     acc;
  operand_t held_diff;
  logic     held_wrap;
  logic     held_err;

  modular_subtractor #(.N_BITS(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A_vector    (A_vector),
    .B_vector    (B_vector),
    .K_vector    (K_vector),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff_vector (diff_vector),
    .wrap_out    (wrap_out),
    .range_err   (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(int a, int b, int k);
    exp_t e;
    int   m;
    int   x;
    m      = 128 - k;
    x      = a - b + ((a < b) ? m : 0);
    x      = ((x % 128) + 128) % 128;
    e.diff = 7'(x);
    e.wrap = (a < b);
    e.err  = (a >= m) || (b >= m);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    #1;
    acc = 1'b0;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty_on_out", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          delivered++;
          chk("diff", diff_vector, e.diff);
          chk("wrap", wrap_out, e.wrap);
          chk("err", range_err, e.err);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(A_vector, B_vector, K_vector));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int k);
    A_vector = operand_t'(a);
    B_vector = operand_t'(b);
    K_vector = operand_t'(k);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (acc) break;
    end
    chk("accept", acc, 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_empty", sb.size(), 0);
    step();
    step();
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    fails     = 0;
    delivered = 0;
    acc       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A_vector  = '0;
    B_vector  = '0;
    K_vector  = operand_t'(20);
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff_vector, 0);
    chk("rst_wrap", wrap_out, 0);
    chk("rst_err", range_err, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Latency: accept cycle, then one empty cycle, then result
    send(69, 45, 20);
    in_valid = 1'b0;
    chk("lat_cycle1_out_valid", out_valid, 0);
    step();
    chk("lat_cycle2_out_valid", out_valid, 1);
    drain();

    // Boundary and range cases back to back
    out_ready = 1'b1;
    send(45, 69, 20);
    send(0, 107, 20);
    send(110, 5, 20);
    send(107, 107, 20);
    send(3, 5, 0);
    send(127, 0, 0);
    drain();

    // Full throughput with random in-range operands
    out_ready = 1'b1;
    K_vector  = operand_t'(20);
    for (int i = 0; i < 8; i++) begin
      A_vector = operand_t'($urandom_range(0, 107));
      B_vector = operand_t'($urandom_range(0, 107));
      in_valid = 1'b1;
      #1;
      chk("thru_in_ready", in_ready, 1);
      step();
    end
    drain();

    // Stall with both stages full, then release with accept
    delivered = 0;
    out_ready = 1'b0;
    send(10, 20, 20);
    send(100, 1, 20);
    A_vector = operand_t'(50);
    B_vector = operand_t'(60);
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", in_ready, 0);
    held_diff = diff_vector;
    held_wrap = wrap_out;
    held_err  = range_err;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_diff", diff_vector, held_diff);
      chk("stall_wrap", wrap_out, held_wrap);
      chk("stall_err", range_err, held_err);
    end
    out_ready = 1'b1;
    send(50, 60, 20);
    send(7, 7, 20);
    drain();
    chk("stall_delivered", delivered, 4);

    // Reset with both stages full discards everything
    out_ready = 1'b0;
    send(30, 90, 20);
    send(90, 30, 20);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff_vector, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) step();
    chk("no_stale_out", out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
